// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or2_qualifier_if.sv
// Request/qualified-output bundle between an or2-merged request source and its qualifier.
// The source side drives I and ACK; the qualifier returns Z, P and PEND.
interface gf180mcu_fd_sc_mcu7t5v0__or2_qualifier_if;
    logic I;
    logic ACK;
    logic Z;
    logic P;
    logic PEND;

    modport master (
        output I,
        output ACK,
        input  Z,
        input  P,
        input  PEND
    );

    modport slave (
        input  I,
        input  ACK,
        output Z,
        output P,
        output PEND
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or2_qualifier.sv
// Synchroniser, symmetric debounce filter, rising-edge pulse and sticky pending flag
// for an asynchronous OR-merged request net.
module gf180mcu_fd_sc_mcu7t5v0__or2_qualifier #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CNT_W       = $clog2(DEBOUNCE + 1)
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__or2_qualifier_if.slave bus,
    inout  wire  VDD,
    inout  wire  VSS
);

    typedef enum logic [1:0] {
        StLow,
        StRiseQual,
        StHigh,
        StFallQual
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   z_q;
    logic                   p_q;
    logic                   pend_q;

    // Supply pins carry no logic; tie them off so they stay visibly consumed.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.I};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StLow;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            p_q     <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            p_q <= 1'b0;
            if (bus.ACK) begin
                pend_q <= 1'b0;
            end
            // Later pend_q <= 1 assignments below override ACK, so a set wins.
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        if (DEBOUNCE == 1) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                            z_q     <= 1'b1;
                            p_q     <= 1'b1;
                            pend_q  <= 1'b1;
                        end else begin
                            state_q <= StRiseQual;
                            cnt_q   <= CntOne;
                        end
                    end
                end
                StRiseQual: begin
                    if (!s) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        z_q     <= 1'b1;
                        p_q     <= 1'b1;
                        pend_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StHigh: begin
                    if (!s) begin
                        if (DEBOUNCE == 1) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                            z_q     <= 1'b0;
                        end else begin
                            state_q <= StFallQual;
                            cnt_q   <= CntOne;
                        end
                    end
                end
                StFallQual: begin
                    // Returning to HIGH from here is not a new rising edge: no pulse.
                    if (s) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        z_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                    z_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Z    = z_q;
    assign bus.P    = p_q;
    assign bus.PEND = pend_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__or2_qualifier.sv
// Bench for the or2 qualifier: default-parameter instance driven from a vector table,
// plus a SYNC_STAGES=3 / DEBOUNCE=1 instance driven by hand-written sequences.
module tb_gf180mcu_fd_sc_mcu7t5v0__or2_qualifier;

    typedef struct {
        string name;
        bit    rst;
        bit    i;
        bit    ack;
        bit    z;
        bit    p;
        bit    pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    wire  vdd = 1'b1;
    wire  vss = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t     vecs[$];
    bit [2:0] sb[$];

    gf180mcu_fd_sc_mcu7t5v0__or2_qualifier_if ifa ();
    gf180mcu_fd_sc_mcu7t5v0__or2_qualifier_if ifb ();

    gf180mcu_fd_sc_mcu7t5v0__or2_qualifier dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (ifa),
        .VDD (vdd),
        .VSS (vss)
    );

    gf180mcu_fd_sc_mcu7t5v0__or2_qualifier #(
        .SYNC_STAGES (3),
        .DEBOUNCE    (1)
    ) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (ifb),
        .VDD (vdd),
        .VSS (vss)
    );

    always #5 clk = ~clk;

    // Append cnt identical cycles: inputs before the edge, expected {Z,P,PEND} after it.
    task automatic add(input string n, input int cnt, input bit rst, input bit i,
                       input bit ack, input bit z, input bit p, input bit pend);
        vec_t v;
        v.name = n; v.rst = rst; v.i = i; v.ack = ack;
        v.z = z; v.p = p; v.pend = pend;
        for (int k = 0; k < cnt; k++) vecs.push_back(v);
    endtask

    task automatic step(input bit sel, input vec_t v, input int idx);
        bit [2:0] got;
        bit [2:0] exp;
        if (sel) begin
            rst_b = v.rst; ifb.I = v.i; ifb.ACK = v.ack;
        end else begin
            rst_a = v.rst; ifa.I = v.i; ifa.ACK = v.ack;
        end
        sb.push_back({v.z, v.p, v.pend});
        @(posedge clk);
        #1;
        got = sel ? {ifb.Z, ifb.P, ifb.PEND} : {ifa.Z, ifa.P, ifa.PEND};
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: Z/P/PEND got %b required %b", v.name, idx, got, exp);
        end
    endtask

    task automatic run_all(input bit sel);
        for (int k = 0; k < vecs.size(); k++) step(sel, vecs[k], k);
        vecs.delete();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.I = 1'b0; ifa.ACK = 1'b0;
        ifb.I = 1'b0; ifb.ACK = 1'b0;

        // Reset holds everything low even with I high; full latency re-runs after release.
        add("reset_hold",  3, 1, 1, 0, 0, 0, 0);
        add("reset_lat",   5, 0, 1, 0, 0, 0, 0);
        add("reset_rise",  1, 0, 1, 0, 1, 1, 1);
        add("reset_high",  1, 0, 1, 0, 1, 0, 1);
        // Falling edge with PEND=1: no pulse, PEND untouched.
        add("fall_lat",    5, 0, 0, 0, 1, 0, 1);
        add("fall_edge",   1, 0, 0, 0, 0, 0, 1);
        add("ack_clear",   1, 0, 0, 1, 0, 0, 0);
        add("ack_idle",    1, 0, 0, 1, 0, 0, 0);
        // Three-cycle glitch is rejected.
        add("glitch_in",   3, 0, 1, 0, 0, 0, 0);
        add("glitch_out",  6, 0, 0, 0, 0, 0, 0);
        // Four-cycle pulse is the shortest accepted; ACK on the setting edge loses.
        add("min_in",      4, 0, 1, 0, 0, 0, 0);
        add("min_wait",    1, 0, 0, 0, 0, 0, 0);
        add("min_set_ack", 1, 0, 0, 1, 1, 1, 1);
        add("min_fall",    3, 0, 0, 0, 1, 0, 1);
        add("min_low",     1, 0, 0, 0, 0, 0, 1);
        add("min_ack",     1, 0, 0, 1, 0, 0, 0);
        // Short low excursion while HIGH is filtered and does not pulse on return.
        add("hi_lat",      5, 0, 1, 0, 0, 0, 0);
        add("hi_rise",     1, 0, 1, 0, 1, 1, 1);
        add("hi_hold",     2, 0, 1, 0, 1, 0, 1);
        add("hi_dip",      3, 0, 0, 0, 1, 0, 1);
        add("hi_back",     6, 0, 1, 0, 1, 0, 1);
        add("hi_fall_lat", 5, 0, 0, 0, 1, 0, 1);
        add("hi_fall",     1, 0, 0, 0, 0, 0, 1);
        run_all(1'b0);

        // SYNC_STAGES=3, DEBOUNCE=1: four-edge latency, single-cycle pulses accepted.
        add("b_reset",     2, 1, 1, 0, 0, 0, 0);
        add("b_lat",       3, 0, 1, 0, 0, 0, 0);
        add("b_rise",      1, 0, 1, 0, 1, 1, 1);
        add("b_high",      1, 0, 1, 0, 1, 0, 1);
        add("b_ack",       1, 0, 1, 1, 1, 0, 0);
        add("b_fall_lat",  3, 0, 0, 0, 1, 0, 0);
        add("b_fall",      1, 0, 0, 0, 0, 0, 0);
        add("b_pulse",     1, 0, 1, 0, 0, 0, 0);
        add("b_pulse_lat", 2, 0, 0, 0, 0, 0, 0);
        add("b_pulse_hi",  1, 0, 0, 0, 1, 1, 1);
        add("b_pulse_lo",  2, 0, 0, 0, 0, 0, 1);
        run_all(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__or2_qualifier.md
Name: gf180mcu_fd_sc_mcu7t5v0__or2_qualifier

Overview:
- Sequential stage directly downstream of the or2 cell.
- Takes the OR-combined request net (the or2 Z output), which may be asynchronous or glitchy, and synchronises and debounces it.
- Produces a clean level, a one-cycle rising-edge pulse, and a sticky pending flag cleared by an acknowledge handshake.
- Used wherever two wake or interrupt sources are OR-merged before entering a clocked domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on I; legal range >= 2.
- DEBOUNCE, 4, consecutive disagreeing cycles required before Z changes; legal range >= 1.
- CNT_W, $clog2(DEBOUNCE+1), debounce counter width; derived, do not override.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  reset; synchronous, active-high.
- I  input  1  raw OR-combined request, driven by or2 Z; asynchronous to CLK.
- ACK  input  1  consumer acknowledge; clears PEND.
- Z  output  1  synchronised, debounced request level.
- P  output  1  one-cycle pulse on each qualified 0->1 transition of Z.
- PEND  output  1  sticky pending flag.
- VDD  inout  1  supply; no functional effect.
- VSS  inout  1  ground; no functional effect.

Behaviour:
- Single clock domain: CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset: while RST=1 at an edge, after that edge the sync chain, counter, state, Z, P and PEND are all 0. RST overrides ACK and I.
- Synchroniser: I passes through SYNC_STAGES flops. S denotes the last flop output. No logic is allowed between stages.
- Filter FSM has four states: LOW (Z=0), RISE_QUAL (Z=0, counting), HIGH (Z=1), FALL_QUAL (Z=1, counting).
  - LOW: S=1 -> RISE_QUAL, CNT=1. If DEBOUNCE=1, go directly to HIGH.
  - RISE_QUAL: S=0 -> LOW, CNT=0 (glitch rejected). S=1 and CNT=DEBOUNCE-1 -> HIGH, CNT=0. Otherwise CNT+1.
  - HIGH and FALL_QUAL: symmetric, with S inverted.
- Z is registered and equals 1 in HIGH and FALL_QUAL.
- Latency: I held stable after a change -> Z follows after exactly SYNC_STAGES+DEBOUNCE edges (6 at defaults).
- Any S excursion shorter than DEBOUNCE cycles is suppressed, and the counter restarts from 0 on return.
- P: registered. P=1 for exactly the one cycle following the edge where the state enters HIGH from RISE_QUAL or LOW. P is never asserted on a falling transition.
- PEND is set on the same edge P is set. It clears on an edge with ACK=1 and no simultaneous set.
  - Set and ACK on the same edge: set wins, PEND=1.
  - ACK while PEND=0: no effect.
  - Z falling does not affect PEND.
- Counter never exceeds DEBOUNCE-1 and never wraps.
- Reset mid-qualification discards the partial count with no pulse. If I is still high after RST deasserts, the full latency is re-run and P fires once.
- VDD and VSS are declared inout and have no functional effect.

Test Plan (defaults unless stated):
- Reset recovery: I=1 with RST=1 for 3 cycles -> Z=P=PEND=0 throughout. Release RST -> Z=1 after the 6th edge, P=1 for exactly that one cycle, PEND=1.
- Glitch reject: I=1 for 3 cycles, then 0 -> Z, P and PEND stay 0. Counter returns to 0.
- Minimum accepted pulse: I=1 for exactly 4 cycles, then 0 -> Z rises 6 edges after the I rise and falls 6 edges after the I fall. P=1 for one cycle only.
- Handshake: PEND=1, ACK=1 for one cycle -> PEND=0 after that edge. ACK coincident with the edge that sets P -> PEND remains 1.
- Falling edge: Z=1, then I=0 held -> Z=0 after 6 edges, P stays 0, PEND unchanged.
- Parameter corner, SYNC_STAGES=3, DEBOUNCE=1: I rise -> Z=1 after exactly 4 edges. A 1-cycle I pulse is accepted and produces one P.
